vector_add_10_input_packer: RTL and testbench

Upstream stage of the 10-element vector-add AXI-Stream wrapper: accepts a narrow AXI-Stream of 15-bit elements (A0..A9 then B0..B9, one element per beat) and assembles them into the 300-bit operand word that the vector-add stage consumes on its slave port. It double-buffers (assembly register plus output register), so the next vector fills while the previous one waits for downstream ready. It checks framing against s_axi_last and resynchronises on errors.

---
 rtl/vector_add_10_input_packer.sv | 123 ++++++++++++
 tb/tb_vector_add_10_input_packer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_add_10_input_packer.sv
// Input packer: gathers a narrow stream of 15-bit elements (A0..A9, B0..B9)
// into one 300-bit operand word. An assembly register fills while the output
// register holds the previous vector, so filling overlaps downstream stalls.
// Framing is counter-defined; s_axi_last is only used to flag/resync errors.
module vector_add_10_input_packer #(
  parameter int ELEM_WIDTH      = 15,
  parameter int ELEM_COUNT      = 20,
  parameter int OUT_DATA_LENGHT = ELEM_WIDTH * ELEM_COUNT
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       enable,
  input  logic [ELEM_WIDTH-1:0]      s_axi_data,
  input  logic                       s_axi_valid,
  input  logic                       s_axi_last,
  output logic                       s_axi_ready,
  output logic [OUT_DATA_LENGHT-1:0] m_axi_data,
  output logic                       m_axi_valid,
  input  logic                       m_axi_ready,
  output logic                       err_short,
  output logic                       err_nolast
);

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ELEM_COUNT - 1);

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [OUT_DATA_LENGHT-1:0] asm_q, asm_d;
  logic                       asm_full_q, asm_full_d;
  logic [OUT_DATA_LENGHT-1:0] m_data_q, m_data_d;
  logic                       m_valid_q, m_valid_d;
  logic                       err_short_q, err_short_d;
  logic                       err_nolast_q, err_nolast_d;

  logic [OUT_DATA_LENGHT-1:0] asm_wr;
  logic                       accept;
  logic                       out_fire;

  assign s_axi_ready = aresetn & enable & ~asm_full_q;
  assign accept      = s_axi_valid & s_axi_ready;
  assign out_fire    = m_valid_q & m_axi_ready;

  assign m_axi_data  = m_data_q;
  assign m_axi_valid = m_valid_q;
  assign err_short   = err_short_q;
  assign err_nolast  = err_nolast_q;

  // Assembly word with the incoming element dropped into slot cnt (slot 0 at the MSBs)
  always_comb begin
    asm_wr = asm_q;
    for (int k = 0; k < ELEM_COUNT; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        asm_wr[ELEM_WIDTH*(ELEM_COUNT-k-1) +: ELEM_WIDTH] = s_axi_data;
      end
    end
  end

  // Element counting, framing checks and assembly-to-output hand-off
  always_comb begin
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    asm_full_d   = asm_full_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    err_short_d  = 1'b0;
    err_nolast_d = 1'b0;

    if (out_fire) begin
      m_valid_d = 1'b0;
    end

    if (asm_full_q) begin
      // input is stalled here, so the only event is the output draining
      if (out_fire) begin
        m_data_d   = asm_q;
        m_valid_d  = 1'b1;
        asm_full_d = 1'b0;
      end
    end else if (accept) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d        = '0;
        asm_d        = asm_wr;
        err_nolast_d = ~s_axi_last;
        if (!m_valid_q || m_axi_ready) begin
          m_data_d  = asm_wr;
          m_valid_d = 1'b1;
        end else begin
          asm_full_d = 1'b1;
        end
      end else if (s_axi_last) begin
        // early last: drop the partial vector and restart at slot 0
        cnt_d       = '0;
        asm_d       = '0;
        err_short_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        asm_d = asm_wr;
      end
    end
  end

  // State registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q        <= '0;
      asm_q        <= '0;
      asm_full_q   <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      err_short_q  <= 1'b0;
      err_nolast_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      asm_full_q   <= asm_full_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      err_short_q  <= err_short_d;
      err_nolast_q <= err_nolast_d;
    end
  end

endmodule

// File: tb/tb_vector_add_10_input_packer.sv
// Bench for the input packer: directed frame table, hand-written stall/reset
// sequences and a random stream, all checked against a queue-based model.
module tb_vector_add_10_input_packer;

  localparam int W = 15;
  localparam int N = 20;
  localparam int L = W * N;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          enable;
  logic [W-1:0]  s_axi_data;
  logic          s_axi_valid;
  logic          s_axi_last;
  logic          s_axi_ready;
  logic [L-1:0]  m_axi_data;
  logic          m_axi_valid;
  logic          m_axi_ready;
  logic          err_short;
  logic          err_nolast;

  vector_add_10_input_packer #(
    .ELEM_WIDTH(W),
    .ELEM_COUNT(N),
    .OUT_DATA_LENGHT(L)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .enable(enable),
    .s_axi_data(s_axi_data),
    .s_axi_valid(s_axi_valid),
    .s_axi_last(s_axi_last),
    .s_axi_ready(s_axi_ready),
    .m_axi_data(m_axi_data),
    .m_axi_valid(m_axi_valid),
    .m_axi_ready(m_axi_ready),
    .err_short(err_short),
    .err_nolast(err_nolast)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  // model: elements of the vector being gathered, and completed vectors not yet taken
  logic [W-1:0] elems[$];
  logic [L-1:0] outq[$];
  bit           exp_es;
  bit           exp_en;

  int es_cnt, en_cnt, emit_cnt;
  bit last_acc;

  typedef struct {
    int base;
    int nbeats;
    int last_idx;
    int gap_at;
    int gap_len;
    int exp_emit;
    int exp_short;
    int exp_nolast;
  } frame_t;

  frame_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return (aresetn === 1'b1) && (enable === 1'b1) && (outq.size() < 2);
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the rising edge
  task automatic cycle();
    bit acc, fire;
    logic [L-1:0] v;
    @(negedge aclk);
    chk("s_ready", 32'(s_axi_ready), 32'(exp_ready()));
    chk("m_valid", 32'(m_axi_valid), 32'(outq.size() > 0));
    if (outq.size() > 0) chk_data("m_data", m_axi_data, outq[0]);
    chk("err_short", 32'(err_short), 32'(exp_es));
    chk("err_nolast", 32'(err_nolast), 32'(exp_en));
    if (err_short === 1'b1) es_cnt++;
    if (err_nolast === 1'b1) en_cnt++;
    if (m_axi_valid === 1'b1 && m_axi_ready === 1'b1) emit_cnt++;
    acc  = (s_axi_valid === 1'b1) && exp_ready();
    fire = (outq.size() > 0) && (m_axi_ready === 1'b1);
    last_acc = acc;
    @(posedge aclk);
    if (aresetn === 1'b1) begin
      exp_es = 1'b0;
      exp_en = 1'b0;
      if (fire) void'(outq.pop_front());
      if (acc) begin
        elems.push_back(s_axi_data);
        if (elems.size() == N) begin
          v = '0;
          for (int k = 0; k < N; k++) v[W*(N-k)-1 -: W] = elems[k];
          outq.push_back(v);
          exp_en = !s_axi_last;
          elems.delete();
        end else if (s_axi_last) begin
          elems.delete();
          exp_es = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    chk("rst_m_valid", 32'(m_axi_valid), 32'd0);
    chk("rst_s_ready", 32'(s_axi_ready), 32'd0);
    chk_data("rst_m_data", m_axi_data, '0);
    chk("rst_err", 32'({err_short, err_nolast}), 32'd0);
    elems.delete();
    outq.delete();
    exp_es = 1'b0;
    exp_en = 1'b0;
    cycle();
    cycle();
    aresetn = 1'b1;
  endtask

  task automatic send_frame(input int base, input int n, input int last_idx,
                            input int gap_at, input int gap_len);
    int guard;
    for (int i = 0; i < n; i++) begin
      s_axi_valid = 1'b1;
      s_axi_data  = W'(base + i);
      s_axi_last  = (i == last_idx);
      if (i == gap_at) begin
        enable = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          cycle();
          chk("gap_ready", 32'(s_axi_ready), 32'd0);
        end
        enable = 1'b1;
      end
      guard = 0;
      cycle();
      while (!last_acc && guard < 200) begin
        cycle();
        guard++;
      end
      if (!last_acc) chk("beat_timeout", 32'd0, 32'd1);
    end
    s_axi_valid = 1'b0;
    s_axi_last  = 1'b0;
  endtask

  initial begin
    tbl[0] = '{base: 1,     nbeats: 20, last_idx: 19, gap_at: -1, gap_len: 0, exp_emit: 1, exp_short: 0, exp_nolast: 0};
    tbl[1] = '{base: 100,   nbeats: 7,  last_idx: 6,  gap_at: -1, gap_len: 0, exp_emit: 0, exp_short: 1, exp_nolast: 0};
    tbl[2] = '{base: 200,   nbeats: 20, last_idx: 19, gap_at: -1, gap_len: 0, exp_emit: 1, exp_short: 0, exp_nolast: 0};
    tbl[3] = '{base: 300,   nbeats: 20, last_idx: -1, gap_at: -1, gap_len: 0, exp_emit: 1, exp_short: 0, exp_nolast: 1};
    tbl[4] = '{base: 400,   nbeats: 20, last_idx: 19, gap_at: 10, gap_len: 5, exp_emit: 1, exp_short: 0, exp_nolast: 0};
    tbl[5] = '{base: 32760, nbeats: 20, last_idx: 19, gap_at: -1, gap_len: 0, exp_emit: 1, exp_short: 0, exp_nolast: 0};

    aresetn     = 1'b0;
    enable      = 1'b0;
    s_axi_data  = '0;
    s_axi_valid = 1'b0;
    s_axi_last  = 1'b0;
    m_axi_ready = 1'b1;
    exp_es      = 1'b0;
    exp_en      = 1'b0;
    #2;
    do_reset();
    enable = 1'b1;
    cycle();

    // directed frames
    for (int i = 0; i < 6; i++) begin
      es_cnt = 0; en_cnt = 0; emit_cnt = 0;
      m_axi_ready = 1'b1;
      send_frame(tbl[i].base, tbl[i].nbeats, tbl[i].last_idx, tbl[i].gap_at, tbl[i].gap_len);
      if (i == 0) begin
        chk("latency_valid", 32'(m_axi_valid), 32'd1);
        chk("a0_slot", 32'(m_axi_data[299:285]), 32'd1);
        chk("b9_slot", 32'(m_axi_data[14:0]), 32'd20);
      end
      repeat (3) cycle();
      chk("tbl_emit", 32'(emit_cnt), 32'(tbl[i].exp_emit));
      chk("tbl_short", 32'(es_cnt), 32'(tbl[i].exp_short));
      chk("tbl_nolast", 32'(en_cnt), 32'(tbl[i].exp_nolast));
    end

    // backpressure: one vector held, one in assembly, input stalls
    emit_cnt = 0;
    m_axi_ready = 1'b0;
    send_frame(1000, 20, 19, -1, 0);
    send_frame(2000, 20, 19, -1, 0);
    chk("stall_ready", 32'(s_axi_ready), 32'd0);
    repeat (3) cycle();
    m_axi_ready = 1'b1;
    cycle();
    cycle();
    chk("stall_drain", 32'(emit_cnt), 32'd2);
    chk("stall_resume", 32'(s_axi_ready), 32'd1);

    // reset mid-vector, then reset with an output held
    send_frame(3000, 12, -1, -1, 0);
    do_reset();
    m_axi_ready = 1'b0;
    send_frame(4000, 20, 19, -1, 0);
    chk("held_valid", 32'(m_axi_valid), 32'd1);
    do_reset();
    emit_cnt = 0;
    m_axi_ready = 1'b1;
    send_frame(5000, 20, 19, -1, 0);
    chk("post_rst_a0", 32'(m_axi_data[299:285]), 32'(W'(5000)));
    repeat (3) cycle();
    chk("post_rst_emit", 32'(emit_cnt), 32'd1);

    // random stream
    for (int c = 0; c < 3000; c++) begin
      s_axi_valid = ($urandom % 4) != 0;
      s_axi_data  = W'($urandom);
      enable      = ($urandom % 16) != 0;
      m_axi_ready = ($urandom % 3) != 0;
      s_axi_last  = (elems.size() == N - 1) ? (($urandom % 8) != 0) : (($urandom % 40) == 0);
      cycle();
    end
    s_axi_valid = 1'b0;
    s_axi_last  = 1'b0;
    enable      = 1'b1;
    m_axi_ready = 1'b1;
    repeat (5) cycle();
    chk("drain_empty", 32'(m_axi_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
